sl_rx_ctrl: RTL

Controller that sequences one SL receiver instance: it programs and verifies the receiver configuration (message length, parity-check enable) and captures every completed-message event (data word plus status word) into a small FIFO. The host drains the FIFO over a valid/ready port. Sits between the host register interface and the SL receiver's config/data/status ports. It also keeps an error counter and a sticky overflow flag.

---
 rtl/sl_rx_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/sl_rx_ctrl.sv
// sl_rx_ctrl
//   Sequences one SL receiver: writes and verifies its configuration word
//   (retrying a limited number of times) and captures every completed-message
//   event into a small first-word-fall-through FIFO that the host drains.
//   It also keeps a saturating error-event counter and a sticky overflow flag.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cfg_in, cfg_load         host config word and one-cycle write request
//   cfg_busy, cfg_err        config sequence running / last sequence failed
//   rx_wr_config_w,
//   rx_wr_enable             config write port to the receiver
//   rx_r_config_w            config readback from the receiver
//   rx_data_w, rx_status_w,
//   rx_data_status_changed   receiver event data, status and strobe
//   msg_data, msg_status,
//   msg_valid, msg_ready     FIFO head and host pop handshake
//   err_cnt, overflow        error-event count, sticky dropped-event flag
//   clr_err                  clears err_cnt, overflow and cfg_err
module sl_rx_ctrl #(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_CFG = 16'h0014,
  parameter int          MAX_RETRY   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cfg_in,
  input  logic        cfg_load,
  output logic        cfg_busy,
  output logic        cfg_err,
  output logic [15:0] rx_wr_config_w,
  output logic        rx_wr_enable,
  input  logic [15:0] rx_r_config_w,
  input  logic [31:0] rx_data_w,
  input  logic [15:0] rx_status_w,
  input  logic        rx_data_status_changed,
  output logic [31:0] msg_data,
  output logic [15:0] msg_status,
  output logic        msg_valid,
  input  logic        msg_ready,
  output logic [7:0]  err_cnt,
  output logic        overflow,
  input  logic        clr_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ATT_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    CFG_WR  = 2'd1,
    CFG_CHK = 2'd2,
    IDLE    = 2'd3
  } stateT;

  // ---------------------------------------------------------------------
  // Config sequencer
  // ---------------------------------------------------------------------
  stateT             stateReg, stateNext;
  logic [15:0]       pendingReg, pendingNext;
  logic [ATT_W-1:0]  attemptReg, attemptNext;
  logic              cfgErrReg;
  logic              cfgErrSet, cfgErrClr;

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg   <= INIT;
      pendingReg <= 16'h0000;
      attemptReg <= '0;
    end else begin
      stateReg   <= stateNext;
      pendingReg <= pendingNext;
      attemptReg <= attemptNext;
    end
  end

  always_comb begin
    stateNext      = stateReg;
    pendingNext    = pendingReg;
    attemptNext    = attemptReg;
    cfgErrSet      = 1'b0;
    cfgErrClr      = 1'b0;
    rx_wr_enable   = 1'b0;
    rx_wr_config_w = 16'h0000;
    cfg_busy       = 1'b1;
    case (stateReg)
      INIT: begin
        pendingNext = DEFAULT_CFG;
        attemptNext = '0;
        stateNext   = CFG_WR;
      end
      CFG_WR: begin
        rx_wr_enable   = 1'b1;
        rx_wr_config_w = pendingReg;
        stateNext      = CFG_CHK;
      end
      CFG_CHK: begin
        if (rx_r_config_w == pendingReg) begin
          cfgErrClr = 1'b1;
          stateNext = IDLE;
        end else if (int'(attemptReg) + 1 < MAX_RETRY) begin
          attemptNext = attemptReg + ATT_W'(1);
          stateNext   = CFG_WR;
        end else begin
          cfgErrSet = 1'b1;
          stateNext = IDLE;
        end
      end
      IDLE: begin
        cfg_busy = 1'b0;
        if (cfg_load) begin
          pendingNext = cfg_in;
          attemptNext = '0;
          stateNext   = CFG_WR;
        end
      end
      default: stateNext = INIT;
    endcase
  end

  // ---------------------------------------------------------------------
  // Capture FIFO (first-word-fall-through, head read combinationally)
  // ---------------------------------------------------------------------
  logic [31:0]      dataMem   [FIFO_DEPTH];
  logic [15:0]      statusMem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtrReg, rdPtrReg;
  logic [CNT_W-1:0] countReg;
  logic             fifoFull, doPush, doPop, dropEvt, errEvt;

  assign msg_valid = (countReg != '0);
  assign fifoFull  = (countReg == CNT_W'(FIFO_DEPTH));
  assign doPop     = msg_valid && msg_ready;
  // A full FIFO still accepts an event when the head leaves in the same cycle.
  assign doPush    = rx_data_status_changed && (!fifoFull || doPop);
  assign dropEvt   = rx_data_status_changed && fifoFull && !doPop;
  assign errEvt    = rx_data_status_changed && (rx_status_w[0] || rx_status_w[4]);

  // Storage is not reset; the head outputs are gated by msg_valid instead.
  always_ff @(posedge clk) begin
    if (doPush) begin
      dataMem[wrPtrReg]   <= rx_data_w;
      statusMem[wrPtrReg] <= rx_status_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else begin
      if (doPush) wrPtrReg <= wrPtrReg + PTR_W'(1);
      if (doPop)  rdPtrReg <= rdPtrReg + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   countReg <= countReg + CNT_W'(1);
        2'b01:   countReg <= countReg - CNT_W'(1);
        default: countReg <= countReg;
      endcase
    end
  end

  assign msg_data   = msg_valid ? dataMem[rdPtrReg]   : 32'h0;
  assign msg_status = msg_valid ? statusMem[rdPtrReg] : 16'h0;

  // ---------------------------------------------------------------------
  // Error bookkeeping; clr_err wins over any same-cycle update
  // ---------------------------------------------------------------------
  logic [7:0] errCntReg;
  logic       overflowReg;

  always_ff @(posedge clk) begin
    if (rst || clr_err) begin
      errCntReg   <= 8'h00;
      overflowReg <= 1'b0;
      cfgErrReg   <= 1'b0;
    end else begin
      if (errEvt && errCntReg != 8'hFF) errCntReg <= errCntReg + 8'h01;
      if (dropEvt) overflowReg <= 1'b1;
      if (cfgErrSet)      cfgErrReg <= 1'b1;
      else if (cfgErrClr) cfgErrReg <= 1'b0;
    end
  end

  assign err_cnt  = errCntReg;
  assign overflow = overflowReg;
  assign cfg_err  = cfgErrReg;

endmodule
